// File: rtl/rpn_display_if.sv
`default_nettype none
// ============================================================================
//  Module      : rpn_display_if
//  Description : Bundle between the calculator core and the RPN result
//                display. The master side issues single-cycle load requests
//                (value, signed_mode, err) and observes busy/done plus the
//                six active-low seven-segment patterns.
//                  load        - single-cycle request to display value
//                  value[7:0]  - stack-top byte
//                  signed_mode - show value as two's complement
//                  err         - show error text instead of a number
//                  busy        - conversion in progress
//                  done        - one-cycle pulse when HEX outputs update
//                  HEX0..HEX5  - active-low segments, bit0=a .. bit6=g
//  Revision    : 1.0 - initial release
// ============================================================================
interface rpn_display_if;
    logic       load;
    logic [7:0] value;
    logic       signed_mode;
    logic       err;
    logic       busy;
    logic       done;
    logic [6:0] HEX0;
    logic [6:0] HEX1;
    logic [6:0] HEX2;
    logic [6:0] HEX3;
    logic [6:0] HEX4;
    logic [6:0] HEX5;

    modport master (
        output load, value, signed_mode, err,
        input  busy, done, HEX0, HEX1, HEX2, HEX3, HEX4, HEX5
    );

    modport slave (
        input  load, value, signed_mode, err,
        output busy, done, HEX0, HEX1, HEX2, HEX3, HEX4, HEX5
    );
endinterface
`default_nettype wire

// File: rtl/rpn_display.sv
`default_nettype none
// ============================================================================
//  Module      : rpn_display
//  Description : Converts an 8-bit calculator result to decimal with a
//                sequential shift-add-3 (double dabble) converter, one bit
//                per cycle, and drives six active-low seven-segment digits.
//                Supports unsigned / two's complement display, an error
//                banner ("Err"), optional leading-zero blanking and a
//                one-deep pending request slot for loads arriving while busy.
//  Ports       : CLOCK_50 - system clock, rising edge
//                KEY1     - asynchronous active-low reset
//                bus      - rpn_display_if.slave (load/value/signed_mode/err
//                           in; busy/done/HEX0..HEX5 out)
//  Revision    : 1.0 - initial release
// ============================================================================
module rpn_display #(
    parameter int BLANK_LZ = 1
) (
    input  wire logic    CLOCK_50,
    input  wire logic    KEY1,
    rpn_display_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        SHOW = 2'd2
    } state_t;

    localparam logic       c_blank_lz  = (BLANK_LZ != 0);
    localparam logic [6:0] c_seg_blank = 7'h7F;
    localparam logic [6:0] c_seg_minus = 7'h3F;
    localparam logic [6:0] c_seg_e     = 7'h06;
    localparam logic [6:0] c_seg_r     = 7'h2F;
    localparam logic [6:0] c_seg_zero  = 7'h40;
    localparam logic [2:0] c_last_iter = 3'd7;

    function automatic logic [6:0] seg7(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'h40;
            4'd1:    s = 7'h79;
            4'd2:    s = 7'h24;
            4'd3:    s = 7'h30;
            4'd4:    s = 7'h19;
            4'd5:    s = 7'h12;
            4'd6:    s = 7'h02;
            4'd7:    s = 7'h78;
            4'd8:    s = 7'h00;
            4'd9:    s = 7'h10;
            default: s = 7'h7F;
        endcase
        return s;
    endfunction

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    state_t      r_state;
    state_t      w_state_next;
    logic [2:0]  r_cnt;
    logic [19:0] r_shift;          // {hundreds, tens, ones, magnitude}
    logic        r_neg;
    logic        r_err;
    logic        r_pend_valid;
    logic [7:0]  r_pend_value;
    logic        r_pend_signed;
    logic        r_pend_err;
    logic [6:0]  r_hex0;
    logic [6:0]  r_hex1;
    logic [6:0]  r_hex2;
    logic [6:0]  r_hex3;
    logic        r_done;

    logic        w_start;
    logic [7:0]  w_src_value;
    logic        w_src_signed;
    logic        w_src_err;
    logic        w_src_neg;
    logic [7:0]  w_mag;
    logic [11:0] w_bcd_adj;
    logic [19:0] w_shift_next;
    logic [3:0]  w_ones;
    logic [3:0]  w_tens;
    logic [3:0]  w_hund;
    logic        w_blank_hund;
    logic        w_blank_tens;
    logic [6:0]  w_hex0_next;
    logic [6:0]  w_hex1_next;
    logic [6:0]  w_hex2_next;
    logic [6:0]  w_hex3_next;

    // ------------------------------------------------------------------
    // Next-state logic. A new conversion starts either from IDLE on a
    // load, or straight out of SHOW when a request is waiting. A load
    // seen during SHOW is the newest request, so it wins over the slot.
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        w_start      = 1'b0;
        w_src_value  = bus.value;
        w_src_signed = bus.signed_mode;
        w_src_err    = bus.err;
        case (r_state)
            IDLE: begin
                if (bus.load) begin
                    w_start      = 1'b1;
                    w_state_next = CONV;
                end
            end
            CONV: begin
                if (r_cnt == c_last_iter) begin
                    w_state_next = SHOW;
                end
            end
            SHOW: begin
                if (bus.load) begin
                    w_start      = 1'b1;
                    w_state_next = CONV;
                end else if (r_pend_valid) begin
                    w_start      = 1'b1;
                    w_src_value  = r_pend_value;
                    w_src_signed = r_pend_signed;
                    w_src_err    = r_pend_err;
                    w_state_next = CONV;
                end else begin
                    w_state_next = IDLE;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLOCK_50 or negedge KEY1) begin
        if (!KEY1) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Magnitude: negative signed values are converted as their absolute
    // value in 8 bits, so 0x80 yields 128.
    assign w_src_neg = w_src_signed & w_src_value[7];
    assign w_mag     = w_src_neg ? (~w_src_value + 8'd1) : w_src_value;

    // Add 3 to every BCD nibble >= 5 before the shift, so the nibble
    // carries correctly into the next decade after doubling.
    for (genvar i = 0; i < 3; i++) begin : g_add3
        logic [3:0] w_nib;
        assign w_nib                = r_shift[8 + 4*i +: 4];
        assign w_bcd_adj[4*i +: 4]  = (w_nib >= 4'd5) ? (w_nib + 4'd3) : w_nib;
    end

    assign w_shift_next = {w_bcd_adj[10:0], r_shift[7:0], 1'b0};

    // ------------------------------------------------------------------
    // Display encoding from the finished BCD value
    // ------------------------------------------------------------------
    assign w_ones       = r_shift[11:8];
    assign w_tens       = r_shift[15:12];
    assign w_hund       = r_shift[19:16];
    assign w_blank_hund = c_blank_lz && (w_hund == 4'd0);
    assign w_blank_tens = w_blank_hund && (w_tens == 4'd0);

    always_comb begin
        w_hex0_next = seg7(w_ones);
        w_hex1_next = w_blank_tens ? c_seg_blank : seg7(w_tens);
        w_hex2_next = w_blank_hund ? c_seg_blank : seg7(w_hund);
        w_hex3_next = r_neg ? c_seg_minus : c_seg_blank;
        if (r_err) begin
            w_hex2_next = c_seg_e;
            w_hex1_next = c_seg_r;
            w_hex0_next = c_seg_r;
            w_hex3_next = c_seg_blank;
        end
    end

    // ------------------------------------------------------------------
    // Datapath, pending slot and display registers. The display registers
    // and done are written on the edge that closes the SHOW cycle; done
    // therefore marks exactly the cycle in which the new pattern appears.
    // ------------------------------------------------------------------
    always_ff @(posedge CLOCK_50 or negedge KEY1) begin
        if (!KEY1) begin
            r_cnt         <= 3'd0;
            r_shift       <= 20'd0;
            r_neg         <= 1'b0;
            r_err         <= 1'b0;
            r_pend_valid  <= 1'b0;
            r_pend_value  <= 8'd0;
            r_pend_signed <= 1'b0;
            r_pend_err    <= 1'b0;
            r_hex0        <= c_seg_zero;
            r_hex1        <= c_seg_blank;
            r_hex2        <= c_seg_blank;
            r_hex3        <= c_seg_blank;
            r_done        <= 1'b0;
        end else begin
            r_done <= (r_state == SHOW);

            if (w_start) begin
                r_shift <= {12'd0, w_mag};
                r_cnt   <= 3'd0;
                r_neg   <= w_src_neg & ~w_src_err;
                r_err   <= w_src_err;
            end else if (r_state == CONV) begin
                r_shift <= w_shift_next;
                r_cnt   <= r_cnt + 3'd1;
            end

            // Only the newest request survives while a conversion runs;
            // leaving SHOW always consumes whatever was waiting.
            if ((r_state == CONV) && bus.load) begin
                r_pend_valid  <= 1'b1;
                r_pend_value  <= bus.value;
                r_pend_signed <= bus.signed_mode;
                r_pend_err    <= bus.err;
            end else if (r_state == SHOW) begin
                r_pend_valid  <= 1'b0;
            end

            if (r_state == SHOW) begin
                r_hex0 <= w_hex0_next;
                r_hex1 <= w_hex1_next;
                r_hex2 <= w_hex2_next;
                r_hex3 <= w_hex3_next;
            end
        end
    end

    assign bus.busy = (r_state != IDLE);
    assign bus.done = r_done;
    assign bus.HEX0 = r_hex0;
    assign bus.HEX1 = r_hex1;
    assign bus.HEX2 = r_hex2;
    assign bus.HEX3 = r_hex3;
    assign bus.HEX4 = c_seg_blank;
    assign bus.HEX5 = c_seg_blank;

endmodule
`default_nettype wire

// File: doc/rpn_display.md
RPN_DISPLAY -- requirements
Module: rpn_display

Interface
REQ-001 Parameter BLANK_LZ, default 1: when 1, leading zeros of the decimal result are blanked; when 0, all three digits are always shown.
REQ-002 CLOCK_50  input  1  system clock; all state updates on its rising edge.
REQ-003 KEY1  input  1  reset, asynchronous and active-low (driven from KEY[1]).
REQ-004 load  input  1  single-cycle request to display value.
REQ-005 value  input  8  stack-top byte from the calculator core.
REQ-006 signed_mode  input  1  1 = show value as two's complement; 0 = show as unsigned; sampled with load.
REQ-007 err  input  1  1 = show error text instead of a number; sampled with load.
REQ-008 busy  output  1  conversion in progress.
REQ-009 done  output  1  one-cycle pulse when HEX outputs update.
REQ-010 HEX0..HEX5  output  7 each  active-low segments, bit0=a … bit6=g; HEX0 is the rightmost digit.

Function
REQ-011 The FSM SHALL have the states IDLE, CONV and SHOW.
- IDLE: waiting.
- CONV: binary-to-BCD by shift-add-3, one bit per cycle, exactly 8 cycles.
- SHOW: one cycle in which the HEX registers are written and done=1; then return to IDLE.
REQ-012 A load in IDLE on edge N SHALL do the following.
- Capture value, signed_mode and err.
- busy=1 from N through N+8.
- HEX registers update and done=1 at edge N+9.
- Total latency is 9 cycles.
REQ-013 Magnitude rules:
- If signed_mode=1 and value[7]=1, the converted magnitude SHALL be (~value+1) as 8-bit unsigned, so 0x80 gives 128.
- In all other cases the magnitude SHALL be value.
REQ-014 Each CONV iteration SHALL first add 3 to every BCD nibble that is >=5, then shift {BCD[11:0], mag} left by one bit.
REQ-015 Digit encodings (active-low):
- 0=0x40, 1=0x79, 2=0x24, 3=0x30, 4=0x19, 5=0x12, 6=0x02, 7=0x78, 8=0x00, 9=0x10
- blank=0x7F, '-'=0x3F, 'E'=0x06, 'r'=0x2F
REQ-016 HEX0..HEX2 SHALL show the ones, tens and hundreds digits; with BLANK_LZ=1 the hundreds digit is blanked if it is 0, and the tens digit is blanked if both hundreds and tens are 0; HEX0 is never blanked.
REQ-017 HEX3 SHALL show '-' when the captured value is negative in signed mode and blank otherwise.
REQ-018 HEX4 and HEX5 SHALL always be blank.
REQ-019 If err=1 is captured, the SHOW state SHALL set HEX2..HEX0 to E,r,r and HEX3 to blank; conversion still runs, so the latency is unchanged.
REQ-020 A load while busy SHALL NOT disturb the conversion in progress.
- The latest such request is held in a one-deep pending register (value, signed_mode, err), and a newer one overwrites it.
- After SHOW, a pending request starts CONV on the next edge without returning to IDLE for a cycle.
REQ-021 A load in the SHOW cycle SHALL be treated as pending per REQ-020.
REQ-022 HEX outputs SHALL hold their last displayed pattern between updates; done SHALL be high only in SHOW.

Reset
REQ-023 While KEY1=0, independent of CLOCK_50:
- state=IDLE, busy=0, done=0, pending cleared, BCD and shift registers cleared;
- HEX0=0x40 and HEX1..HEX5=0x7F.
REQ-024 Reset asserted in mid-conversion SHALL abort the conversion; no done pulse follows, and the first load after release behaves per REQ-012.

Verification
REQ-025 The bench SHALL cover the following directed scenarios:
- Reset, then load 0xAE with signed_mode=0 -> 9 cycles later done=1, HEX2..HEX0=0x79,0x78,0x19 ("174"), HEX3=0x7F.
- Load 0xAE with signed_mode=1 -> HEX3=0x3F, HEX2=0x7F, HEX1=0x00, HEX0=0x24 ("-82"); then load 0x80 signed -> "-128" (0x3F, 0x79, 0x24, 0x00).
- Load 0x00 -> HEX0=0x40 and HEX1..HEX3=0x7F; repeat with BLANK_LZ=0 -> HEX2..HEX0=0x40,0x40,0x40.
- Load 0x81 with err=1 -> HEX2..HEX0=0x06,0x2F,0x2F and latency 9 cycles.
- Load 0x05, then load 0x63 then 0xFF during busy -> "5" shown, then 0xFF ("255") shown 9 cycles after the first SHOW, and 0x63 is never shown.
- Assert KEY1 at cycle 4 of a conversion -> outputs take reset values immediately; no done pulse after release.
